// File: rtl/mod5_pkg.sv
// Shared definitions for the mod-5 check scheduler: FSM states, residue
// constants and the single-bit residue step.
package mod5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;

  // Next residue after appending one bit MSB-first: (2*r + b) mod 5.
  function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
    logic [2:0] nxt;
    case (r)
      R0:      nxt = b ? R1 : R0;
      R1:      nxt = b ? R3 : R2;
      R2:      nxt = b ? R0 : R4;
      R3:      nxt = b ? R2 : R1;
      R4:      nxt = b ? R4 : R3;
      default: nxt = R0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mod5_check_scheduler_if.sv
// Requester handshake and result bus of the mod-5 check scheduler.
interface mod5_check_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_div5;
  logic [2:0]            res_residue;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, res_valid, res_div5, res_residue, res_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, res_valid, res_div5, res_residue, res_id, busy
  );

endinterface

// File: rtl/mod5_serial_residue.sv
// Serial mod-5 residue accumulator: consumes one bit per enabled cycle,
// MSB first; clear has priority over en.
module mod5_serial_residue
  import mod5_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [2:0] residue
);

  logic [2:0] residue_d, residue_q;

  always_comb begin
    // NOTE: default assignment first, so every path assigns residue_d and no latch is inferred.
    residue_d = residue_q;
    if (clear) begin
      residue_d = R0;
    end else if (en) begin
      residue_d = mod5_step(residue_q, bit_in);
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      residue_q <= R0;
    end else begin
      residue_q <= residue_d;
    end
  end

  assign residue = residue_q;

endmodule

// File: rtl/mod5_check_scheduler.sv
// Round-robin scheduler sharing one serial mod-5 residue engine among NREQ
// requesters; one word in flight at a time, results reported per word.
module mod5_check_scheduler
  import mod5_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                   clk,
  input logic                   reset,
  mod5_check_scheduler_if.slave bus
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [2:0]       res_residue_q, res_residue_d;
  logic             res_div5_q, res_div5_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  ready;
  logic             handshake;
  logic             eng_clear;
  logic             eng_en;
  logic [2:0]       residue;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign handshake = |(bus.req_valid & ready);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    cur_id_d      = cur_id_q;
    last_grant_d  = last_grant_q;
    res_residue_d = res_residue_q;
    res_div5_d    = res_div5_q;
    res_id_d      = res_id_q;
    eng_clear     = 1'b0;
    eng_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          shreg_d      = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
          cur_id_d     = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = '0;
          eng_clear    = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        eng_en  = 1'b1;
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_residue_d = residue;
        res_div5_d    = (residue == R0);
        res_id_d      = cur_id_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      cur_id_q      <= '0;
      last_grant_q  <= ID_LAST;
      res_residue_q <= R0;
      res_div5_q    <= 1'b0;
      res_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      cur_id_q      <= cur_id_d;
      last_grant_q  <= last_grant_d;
      res_residue_q <= res_residue_d;
      res_div5_q    <= res_div5_d;
      res_id_q      <= res_id_d;
    end
  end

  mod5_serial_residue u_engine (
    .clk     (clk),
    .reset   (reset),
    .clear   (eng_clear),
    .en      (eng_en),
    .bit_in  (shreg_q[WIDTH-1]),
    .residue (residue)
  );

  // During DONE the fresh result is forwarded so it is valid with res_valid;
  // afterwards the registered copy holds it until the next DONE.
  assign bus.req_ready   = ready;
  assign bus.res_valid   = (state_q == ST_DONE);
  assign bus.res_residue = (state_q == ST_DONE) ? residue : res_residue_q;
  assign bus.res_div5    = (state_q == ST_DONE) ? (residue == R0) : res_div5_q;
  assign bus.res_id      = (state_q == ST_DONE) ? cur_id_q : res_id_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod5_check_scheduler.sv
// Scoreboard bench for mod5_check_scheduler: directed words with hand-computed
// residues and grant orders; a negedge monitor checks grants, timing and results.
module tb_mod5_check_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int LAT   = WIDTH + 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2:0]     residue;
    logic           div5;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod5_check_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  mod5_check_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  res_t           exp_res_q[$];
  logic [IDW-1:0] exp_grant_q[$];
  int             hs_cycle_q[$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int busy_from = -100;
  int busy_to = -100;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: grants, busy window, ready sanity and results against the queues.
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] hs;
    logic            exp_busy;
    int              gid;
    int              hc;
    res_t            er;
    if (!reset) begin
      exp_busy = (cycle >= busy_from) && (cycle <= busy_to);
      check("busy", bus.busy, exp_busy);
      check("ready_onehot", $countones(bus.req_ready) <= 1, 1);
      if (exp_busy) check("ready_while_busy", bus.req_ready, 0);
      hs = bus.req_valid & bus.req_ready;
      if (hs != '0) begin
        gid = 0;
        for (int i = 0; i < NREQ; i++) if (hs[i]) gid = i;
        check("grant_expected", exp_grant_q.size() > 0, 1);
        if (exp_grant_q.size() > 0) check("grant_id", gid, exp_grant_q.pop_front());
        hs_cycle_q.push_back(cycle);
        busy_from = cycle + 1;
        busy_to   = cycle + LAT;
      end
      if (bus.res_valid) begin
        check("result_expected", exp_res_q.size() > 0, 1);
        if (exp_res_q.size() > 0) begin
          er = exp_res_q.pop_front();
          check("res_id", bus.res_id, er.id);
          check("res_residue", bus.res_residue, er.residue);
          check("res_div5", bus.res_div5, er.div5);
        end
        if (hs_cycle_q.size() > 0) begin
          hc = hs_cycle_q.pop_front();
          check("res_latency", cycle - hc, LAT);
        end
      end
    end
  end

  task automatic expect_word(input int id, input logic [2:0] r);
    res_t e;
    e.id      = IDW'(id);
    e.residue = r;
    e.div5    = (r == 3'd0);
    exp_grant_q.push_back(IDW'(id));
    exp_res_q.push_back(e);
  endtask

  // Asserts reset immediately, checks reset values, then releases it.
  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_div5", bus.res_div5, 0);
    check("rst_res_residue", bus.res_residue, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    exp_res_q.delete();
    exp_grant_q.delete();
    hs_cycle_q.delete();
    busy_from = -100;
    busy_to   = -100;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for requester i to handshake; returns its cycle and
  // leaves the caller just after that clock edge.
  task automatic wait_hs(input int i, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("hs_timeout", n < 64, 1);
    c = cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic [2:0] r);
    int c;
    expect_word(i, r);
    bus.req_data[i*WIDTH +: WIDTH] = d;
    bus.req_valid[i] = 1'b1;
    wait_hs(i, c);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_res_q.size() != 0 || exp_grant_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_res_q.size() + exp_grant_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int prev;
    int order[4];
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Single word after reset, then the residue corner cases.
    do_reset();
    send(0, 8'd25, 3'd0);
    wait_drain(40);
    send(0, 8'd254, 3'd4);
    send(1, 8'd7,   3'd2);
    send(2, 8'd0,   3'd0);
    send(3, 8'd255, 3'd0);
    wait_drain(80);
    check("hold_res_id", bus.res_id, 3);
    check("hold_res_residue", bus.res_residue, 0);
    check("hold_res_div5", bus.res_div5, 1);

    // All four requesters valid from reset: grants 0,1,2,3 spaced WIDTH+2.
    do_reset();
    expect_word(0, 3'd0);
    expect_word(1, 3'd1);
    expect_word(2, 3'd2);
    expect_word(3, 3'd3);
    bus.req_data  = {8'd13, 8'd12, 8'd11, 8'd10};
    bus.req_valid = '1;
    prev = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_hs(k, c);
      bus.req_valid[k] = 1'b0;
      if (k > 0) check("hs_spacing_all", c - prev, WIDTH + 2);
      prev = c;
    end
    wait_drain(60);

    // req1 granted first, then req1/req3 held: grants alternate 3,1,3,1.
    do_reset();
    send(1, 8'd20, 3'd0);
    wait_drain(40);
    order = '{3, 1, 3, 1};
    bus.req_data[1*WIDTH +: WIDTH] = 8'd6;
    bus.req_data[3*WIDTH +: WIDTH] = 8'd9;
    for (int k = 0; k < 4; k++) expect_word(order[k], (order[k] == 3) ? 3'd4 : 3'd1);
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_hs(order[k], c);
      if (k > 0) check("hs_spacing_pair", c - prev, WIDTH + 2);
      prev = c;
    end
    bus.req_valid = '0;
    wait_drain(60);

    // Reset in the 4th SHIFT cycle aborts the word; arbitration restarts at req0.
    exp_grant_q.push_back(2'd2);
    bus.req_data[2*WIDTH +: WIDTH] = 8'd13;
    bus.req_valid[2] = 1'b1;
    wait_hs(2, c);
    bus.req_valid[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", bus.busy, 1);
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    expect_word(1, 3'd0);
    expect_word(3, 3'd3);
    bus.req_data[1*WIDTH +: WIDTH] = 8'd50;
    bus.req_data[3*WIDTH +: WIDTH] = 8'd33;
    bus.req_valid[1] = 1'b1;
    bus.req_valid[3] = 1'b1;
    wait_hs(1, c);
    bus.req_valid[1] = 1'b0;
    wait_hs(3, c);
    bus.req_valid[3] = 1'b0;
    wait_drain(60);

    // One-cycle req2 pulse while busy: never granted, never reported.
    send(0, 8'd100, 3'd0);
    bus.req_data[2*WIDTH +: WIDTH] = 8'd77;
    bus.req_valid[2] = 1'b1;
    @(negedge clk);
    check("pulse_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    wait_drain(40);
    repeat (15) @(posedge clk);
    #1;
    check("final_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
